// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one-cycle sign fixup.
// Optional macro MULDIV_EARLY_OUT_EN adds a fast path for zero multiplies and small-dividend divides.
module rv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, next_state;
  logic [XLEN-1:0]   acc, lo, opnd;
  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q;
  logic [CNT_W-1:0]  counter;

  logic              accept, a_signed, b_signed, in_a_neg, in_b_neg;
  logic              div_zero, div_ovf, early, special;
  logic [XLEN-1:0]   mag_a, mag_b, spec_acc, spec_lo;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic              neg_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fixup_result;

  assign accept   = start && !flush && (state == IDLE || state == DONE);
  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign in_a_neg = a_signed && a[XLEN-1];
  assign in_b_neg = b_signed && b[XLEN-1];
  assign mag_a    = in_a_neg ? -a : a;
  assign mag_b    = in_b_neg ? -b : b;
  assign div_zero = op[2] && (b == '0);
  assign div_ovf  = ((op == 3'b100) || (op == 3'b110)) && (a == MOST_NEG) && (&b);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = (!op[2] && (a == '0 || b == '0)) ||
                 (op[2] && (b != '0) && (mag_a < mag_b));
`else
  assign early = 1'b0;
`endif

  assign special = div_zero || div_ovf || early;

  // Special cases preload the final signed quotient (lo) and remainder (acc) so FIXUP only selects.
  always_comb begin
    spec_acc = '0;
    spec_lo  = '0;
    if (div_zero) begin
      spec_acc = a;
      spec_lo  = '1;
    end else if (div_ovf) begin
      spec_lo  = a;
    end else if (op[2]) begin
      spec_acc = a;
    end
  end

  assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc, lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = ~div_diff[XLEN];
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

  assign neg_res  = a_neg_q ^ b_neg_q;
  assign prod_fix = neg_res ? -{acc, lo} : {acc, lo};
  assign quo_fix  = neg_res ? -lo : lo;
  assign rem_fix  = a_neg_q ? -acc : acc;

  always_comb begin
    fixup_result = rem_fix;
    case (op_q)
      3'b000:                 fixup_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixup_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixup_result = quo_fix;
      default:                fixup_result = rem_fix;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = special ? FIXUP : CALC;
      CALC:    if (counter == CNT_W'(XLEN - 1)) next_state = FIXUP;
      FIXUP:   next_state = DONE;
      DONE:    next_state = accept ? (special ? FIXUP : CALC) : IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // acc/lo hold {product_hi, product_lo} for multiplies and {remainder, quotient} for divides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      acc     <= '0;
      lo      <= '0;
      opnd    <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      counter <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == CALC) || (next_state == FIXUP);
      done  <= (next_state == DONE);
      if (accept) begin
        op_q    <= op;
        counter <= '0;
        opnd    <= mag_b;
        if (special) begin
          a_neg_q <= 1'b0;
          b_neg_q <= 1'b0;
          acc     <= spec_acc;
          lo      <= spec_lo;
        end else begin
          a_neg_q <= in_a_neg;
          b_neg_q <= in_b_neg;
          acc     <= '0;
          lo      <= mag_a;
        end
      end else if (state == CALC) begin
        counter <= counter + CNT_W'(1);
        if (op_q[2]) begin
          acc <= div_rem;
          lo  <= {lo[XLEN-2:0], div_ge};
        end else begin
          acc <= mul_sum[XLEN:1];
          lo  <= {mul_sum[0], lo[XLEN-1:1]};
        end
      end else if (state == FIXUP && !flush) begin
        result <= fixup_result;
      end
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed self-checking bench for rv_muldiv_unit (XLEN=32); define MULDIV_EARLY_OUT_EN to also run the fast-path vectors.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  // Launches one op; returns the cycle index of done (-1 on timeout) with cycle 0 being the accept cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] res, output int busy_cycles);
    lat = -1;
    res = 32'hxxxxxxxx;
    busy_cycles = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        res = result;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", result); else passed++;
  endtask

  task automatic test_mul();
    int lat, bc;
    logic [31:0] res;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, lat, res, bc);
    checks++; if (lat !== 34) $display("[TB] FAIL mul_latency: got %0d expected 34", lat); else passed++;
    checks++; if (res !== 32'hFFFFFFEB) $display("[TB] FAIL mul_result: got %h expected ffffffeb", res); else passed++;
    checks++; if (bc !== 33) $display("[TB] FAIL mul_busy_cycles: got %0d expected 33", bc); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL mul_busy_at_done: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_high_products();
    logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] xa  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] xb  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int lat, bc;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], xa[i], xb[i], lat, res, bc);
      checks++; if (res !== exp[i]) $display("[TB] FAIL high_product_%0d: got %h expected %h", i, res, exp[i]); else passed++;
      checks++; if (lat !== 34) $display("[TB] FAIL high_latency_%0d: got %0d expected 34", i, lat); else passed++;
    end
  endtask

  task automatic test_divide();
    logic [2:0]  ops [3] = '{3'b100, 3'b110, 3'b101};
    logic [31:0] exp [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC};
    int lat, bc;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'hFFFFFFF9, 32'd2, lat, res, bc);
      checks++; if (res !== exp[i]) $display("[TB] FAIL divide_%0d: got %h expected %h", i, res, exp[i]); else passed++;
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] xa  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] xb  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int lat, bc;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xa[i], xb[i], lat, res, bc);
      checks++; if (res !== exp[i]) $display("[TB] FAIL special_result_%0d: got %h expected %h", i, res, exp[i]); else passed++;
      checks++; if (lat !== 2) $display("[TB] FAIL special_latency_%0d: got %0d expected 2", i, lat); else passed++;
    end
  endtask

  task automatic test_flush();
    int lat, bc, dones;
    logic [31:0] res;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, lat, res, bc);
    checks++; if (res !== 32'hFFFFFFEB) $display("[TB] FAIL flush_setup: got %h expected ffffffeb", res); else passed++;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL flush_busy_before: got %b expected 1", busy); else passed++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL flush_busy_after: got %b expected 0", busy); else passed++;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) $display("[TB] FAIL flush_no_done: got %0d pulses expected 0", dones); else passed++;
    checks++; if (result !== 32'hFFFFFFEB) $display("[TB] FAIL flush_result_kept: got %h expected ffffffeb", result); else passed++;
  endtask

  task automatic test_start_while_busy();
    int lat;
    logic [31:0] res;
    lat = -1;
    res = 32'hxxxxxxxx;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd7; b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        res = result;
        break;
      end
      if (k == 5) begin
        start = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (lat !== 34) $display("[TB] FAIL ignore_start_latency: got %0d expected 34", lat); else passed++;
    checks++; if (res !== 32'hFFFFFFEB) $display("[TB] FAIL ignore_start_result: got %h expected ffffffeb", res); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hFFFFFFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL midrst_done: got %b expected 0", done); else passed++;
    checks++; if (result !== 32'h0) $display("[TB] FAIL midrst_result: got %h expected 00000000", result); else passed++;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", dones); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bc, lat2, bc2;
    logic [31:0] res, res2;
    run_op(3'b101, 32'hFFFFFFF9, 32'd2, lat, res, bc);
    checks++; if (lat !== 34) $display("[TB] FAIL b2b_first_latency: got %0d expected 34", lat); else passed++;
    checks++; if (res !== 32'h7FFFFFFC) $display("[TB] FAIL b2b_first_result: got %h expected 7ffffffc", res); else passed++;
    start = 1'b1; op = 3'b000; a = 32'd7; b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL b2b_no_gap: got %b expected 1", busy); else passed++;
    lat2 = -1;
    res2 = 32'hxxxxxxxx;
    bc2 = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat2 = k;
        res2 = result;
        break;
      end
      if (busy) bc2++;
      @(negedge clk);
    end
    checks++; if (lat2 !== 34) $display("[TB] FAIL b2b_second_latency: got %0d expected 34", lat2); else passed++;
    checks++; if (res2 !== 32'hFFFFFFEB) $display("[TB] FAIL b2b_second_result: got %h expected ffffffeb", res2); else passed++;
    checks++; if (bc2 !== 33) $display("[TB] FAIL b2b_second_busy: got %0d expected 33", bc2); else passed++;
  endtask

`ifdef MULDIV_EARLY_OUT_EN
  task automatic test_early_out();
    logic [2:0]  ops [3] = '{3'b000, 3'b101, 3'b111};
    logic [31:0] xa  [3] = '{32'd0, 32'd3, 32'd3};
    logic [31:0] xb  [3] = '{32'd5, 32'd9, 32'd9};
    logic [31:0] exp [3] = '{32'd0, 32'd0, 32'd3};
    int lat, bc;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], xa[i], xb[i], lat, res, bc);
      checks++; if (res !== exp[i]) $display("[TB] FAIL early_result_%0d: got %h expected %h", i, res, exp[i]); else passed++;
      checks++; if (lat !== 2) $display("[TB] FAIL early_latency_%0d: got %0d expected 2", i, lat); else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_high_products();
    test_divide();
    test_special();
    test_flush();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
`ifdef MULDIV_EARLY_OUT_EN
    test_early_out();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
